// File: rtl/pico_mem_responder.sv
// Cycle-exact PicoRV32 native-bus memory with byte-strobe writes, programmable wait states,
// a backdoor load port, sticky error flags and saturating per-class access counters.
module pico_mem_responder #(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_valid,
    input  logic          mem_instr,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic          mem_ready,
    output logic [31:0]   mem_rdata,
    input  logic [3:0]    wait_cycles,
    input  logic          bd_we,
    input  logic [AW-1:0] bd_addr,
    input  logic [31:0]   bd_wdata,
    output logic          access_err,
    output logic [31:0]   err_addr,
    output logic          protocol_err,
    output logic [31:0]   fetch_cnt,
    output logic [31:0]   load_cnt,
    output logic [31:0]   store_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, next_state;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          instr_q;
    logic [3:0]    cnt_q;

    logic [31:0]   mem [DEPTH];

    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic [32:0]   off33;
    logic [32:0]   idx33;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          enter_resp;

    // With zero wait states the memory action happens on the acceptance edge itself,
    // so decode from the live bus in IDLE and from the latched request otherwise.
    always_comb begin
        req_addr  = addr_q;
        req_wdata = wdata_q;
        req_wstrb = wstrb_q;
        if (state == IDLE) begin
            req_addr  = mem_addr;
            req_wdata = mem_wdata;
            req_wstrb = mem_wstrb;
        end
        off33    = {1'b0, req_addr} - {1'b0, BASE_ADDR};
        idx33    = off33 >> 2;
        in_range = (req_addr >= BASE_ADDR) && (idx33 < 33'(DEPTH));
        idx      = idx33[AW-1:0];
        enter_resp = ((state == IDLE) && mem_valid && (wait_cycles == 4'd0)) ||
                     ((state == WAIT) && mem_valid && (cnt_q == 4'd1));
    end

    always_comb begin
        next_state = state;
        mem_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid)
                    next_state = (wait_cycles == 4'd0) ? RESP : WAIT;
            end
            WAIT: begin
                if (!mem_valid)
                    next_state = IDLE;
                else if (cnt_q == 4'd1)
                    next_state = RESP;
            end
            RESP: begin
                mem_ready  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            instr_q      <= 1'b0;
            cnt_q        <= '0;
            mem_rdata    <= '0;
            access_err   <= 1'b0;
            err_addr     <= '0;
            protocol_err <= 1'b0;
            fetch_cnt    <= '0;
            load_cnt     <= '0;
            store_cnt    <= '0;
        end else begin
            state <= next_state;

            if (state == IDLE && mem_valid) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
                instr_q <= mem_instr;
                cnt_q   <= wait_cycles;
            end else if (state == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (state == WAIT && !mem_valid)
                protocol_err <= 1'b1;

            if (enter_resp) begin
                if (req_wstrb == 4'b0000)
                    mem_rdata <= in_range ? mem[idx] : ERR_DATA;
                if (!in_range) begin
                    access_err <= 1'b1;
                    if (!access_err)
                        err_addr <= req_addr;
                end
            end

            if (state == RESP) begin
                if (wstrb_q != 4'b0000) begin
                    if (store_cnt != 32'hFFFF_FFFF) store_cnt <= store_cnt + 32'd1;
                end else if (instr_q) begin
                    if (fetch_cnt != 32'hFFFF_FFFF) fetch_cnt <= fetch_cnt + 32'd1;
                end else begin
                    if (load_cnt != 32'hFFFF_FFFF) load_cnt <= load_cnt + 32'd1;
                end
            end
        end
    end

    // Bus bytes are assigned after the backdoor word so strobed bytes win on a same-word collision.
    always_ff @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_wdata;
        if (reset && enter_resp && in_range && (req_wstrb != 4'b0000)) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wstrb[b])
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_pico_mem_responder.sv
// Directed self-checking bench for pico_mem_responder: latency, strobes, errors, protocol, reset abort.
module tb_pico_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [3:0]  wait_cycles = '0;
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = '0;
    logic [31:0] bd_wdata = '0;
    logic        access_err;
    logic [31:0] err_addr;
    logic        protocol_err;
    logic [31:0] fetch_cnt;
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;

    int checks = 0;
    int failures = 0;

    pico_mem_responder dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wait_cycles(wait_cycles),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .access_err(access_err), .err_addr(err_addr), .protocol_err(protocol_err),
        .fetch_cnt(fetch_cnt), .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic backdoor(input logic [11:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Called #1 after a rising edge; returns edges-until-ready and the sampled read data.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                                 input logic ins, input logic [3:0] wc, input logic zero_wait_mid,
                                 output int lat, output logic [31:0] rd);
        logic got = 1'b0;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
        mem_instr = ins; wait_cycles = wc;
        lat = 0;
        while (lat < 40 && !got) begin
            @(posedge clk); #1;
            lat++;
            bd_we = 1'b0;
            if (zero_wait_mid) wait_cycles = 4'd0;
            if (mem_ready) got = 1'b1;
        end
        rd = mem_rdata;
        checkOutput("ready_seen", {31'd0, got}, 32'd1);
        mem_valid = 1'b0; mem_wstrb = 4'b0000; mem_instr = 1'b0;
        @(posedge clk); #1;
        checkOutput("ready_pulse", {31'd0, mem_ready}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] rd;
        logic saw_ready;

        #2;
        checkOutput("rst_ready", {31'd0, mem_ready}, 32'd0);
        checkOutput("rst_rdata", mem_rdata, 32'd0);
        checkOutput("rst_cnts", fetch_cnt | load_cnt | store_cnt, 32'd0);
        checkOutput("rst_flags", {30'd0, access_err, protocol_err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        backdoor(12'd5, 32'h1234_5678);
        applyStimulus(32'h14, 32'h0, 4'b0000, 1'b0, 4'd0, 1'b0, lat, rd);
        checkOutput("rd_w0_lat", lat, 32'd1);
        checkOutput("rd_w0_data", rd, 32'h1234_5678);
        checkOutput("load_cnt1", load_cnt, 32'd1);

        applyStimulus(32'h14, 32'h0, 4'b0000, 1'b0, 4'd3, 1'b0, lat, rd);
        checkOutput("rd_w3_lat", lat, 32'd4);
        checkOutput("rd_w3_data", rd, 32'h1234_5678);
        applyStimulus(32'h14, 32'h0, 4'b0000, 1'b0, 4'd3, 1'b1, lat, rd);
        checkOutput("rd_w3chg_lat", lat, 32'd4);
        checkOutput("rd_w3chg_data", rd, 32'h1234_5678);
        checkOutput("load_cnt3", load_cnt, 32'd3);

        backdoor(12'd2, 32'hAABB_CCDD);
        applyStimulus(32'h8, 32'h1122_3344, 4'b0101, 1'b0, 4'd0, 1'b0, lat, rd);
        checkOutput("wr_rdata_hold", rd, 32'h1234_5678);
        checkOutput("store_cnt1", store_cnt, 32'd1);
        applyStimulus(32'h8, 32'h0, 4'b0000, 1'b0, 4'd1, 1'b0, lat, rd);
        checkOutput("wr_readback", rd, 32'hAA22_CC44);
        checkOutput("rd_w1_lat", lat, 32'd2);

        applyStimulus(32'h4000, 32'h0, 4'b0000, 1'b0, 4'd0, 1'b0, lat, rd);
        checkOutput("oor_data", rd, 32'hDEAD_BEEF);
        checkOutput("oor_flag", {31'd0, access_err}, 32'd1);
        checkOutput("oor_addr", err_addr, 32'h4000);
        applyStimulus(32'hFFFF_FFFC, 32'h0, 4'b0000, 1'b0, 4'd0, 1'b0, lat, rd);
        checkOutput("oor2_data", rd, 32'hDEAD_BEEF);
        checkOutput("oor2_addr", err_addr, 32'h4000);

        bd_we = 1'b1; bd_addr = 12'd7; bd_wdata = 32'h9988_7766;
        applyStimulus(32'h1C, 32'h0000_AAAA, 4'b0011, 1'b0, 4'd0, 1'b0, lat, rd);
        applyStimulus(32'h1C, 32'h0, 4'b0000, 1'b0, 4'd0, 1'b0, lat, rd);
        checkOutput("collide_data", rd, 32'h9988_AAAA);
        checkOutput("store_cnt2", store_cnt, 32'd2);
        checkOutput("load_cnt7", load_cnt, 32'd7);

        mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h14; mem_wstrb = 4'b0000; wait_cycles = 4'd2;
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_instr = 1'b0;
        saw_ready = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (mem_ready) saw_ready = 1'b1;
        end
        checkOutput("proto_noready", {31'd0, saw_ready}, 32'd0);
        checkOutput("proto_flag", {31'd0, protocol_err}, 32'd1);
        checkOutput("proto_fetch0", fetch_cnt, 32'd0);
        applyStimulus(32'h14, 32'h0, 4'b0000, 1'b1, 4'd0, 1'b0, lat, rd);
        checkOutput("fetch_data", rd, 32'h1234_5678);
        checkOutput("fetch_cnt1", fetch_cnt, 32'd1);

        mem_valid = 1'b1; mem_addr = 32'h14; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'b1111; wait_cycles = 4'd4;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checkOutput("abort_ready", {31'd0, mem_ready}, 32'd0);
        checkOutput("abort_cnts", fetch_cnt | load_cnt | store_cnt, 32'd0);
        checkOutput("abort_flags", {30'd0, access_err, protocol_err}, 32'd0);
        checkOutput("abort_erraddr", err_addr, 32'd0);
        mem_valid = 1'b0; mem_wstrb = 4'b0000;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        applyStimulus(32'h14, 32'h0, 4'b0000, 1'b0, 4'd0, 1'b0, lat, rd);
        checkOutput("abort_word_kept", rd, 32'h1234_5678);
        checkOutput("abort_load_cnt", load_cnt, 32'd1);
        checkOutput("abort_store_cnt", store_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
